// File: rtl/neuron_scheduler_pkg.sv
// Shared types and default sizes for the time-multiplexed neuron scheduler.
// The wrapper and the bench take their default widths from here.
package neuron_scheduler_pkg;

    localparam int DEF_N_NEURONS   = 4;
    localparam int DEF_N_STAGE     = 3;
    localparam int DEF_N_MEMBRANE  = DEF_N_STAGE + 2;
    localparam int DEF_N_THRESHOLD = DEF_N_MEMBRANE - 1;
    localparam int IDX_W           = $clog2(DEF_N_NEURONS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/neuron.sv
// Leaky integrate-and-fire datapath: one neuron update per cycle, purely
// combinational, saturating membrane, reset-to-zero on spike.
module neuron #(
    parameter int N_STAGE     = 3,
    parameter int N_MEMBRANE  = N_STAGE + 2,
    parameter int N_THRESHOLD = N_MEMBRANE - 1
) (
    input  logic [2**N_STAGE-1:0]        inputs,
    input  logic [2**N_STAGE-1:0]        weights,
    input  logic [N_THRESHOLD-1:0]       threshold,
    input  logic [2:0]                   shift,
    input  logic signed [N_MEMBRANE-1:0] membrane,
    output logic signed [N_MEMBRANE-1:0] new_membrane,
    output logic                         is_spike
);

    localparam int N_SYN = 2 ** N_STAGE;
    localparam int W     = N_MEMBRANE + 2;

    localparam logic signed [W-1:0] MAX_W = W'(2 ** (N_MEMBRANE - 1) - 1);
    localparam logic signed [W-1:0] MIN_W = -MAX_W - W'(1);

    logic        [W-1:0]          syn_cnt;
    logic signed [W-1:0]          mem_ext;
    logic signed [W-1:0]          leak;
    logic signed [W-1:0]          sum;
    logic signed [N_MEMBRANE-1:0] sat;

    always_comb begin
        syn_cnt = '0;
        for (int i = 0; i < N_SYN; i++) begin
            syn_cnt = syn_cnt + W'(inputs[i] & weights[i]);
        end
    end

    // shift 0 means no leak; otherwise subtract membrane >>> shift
    always_comb begin
        mem_ext = {{2{membrane[N_MEMBRANE-1]}}, membrane};
        leak    = (shift == 3'd0) ? '0 : (mem_ext >>> shift);
        sum     = mem_ext - leak + $signed(syn_cnt);
    end

    always_comb begin
        if (sum > MAX_W) begin
            sat = MAX_W[N_MEMBRANE-1:0];
        end else if (sum < MIN_W) begin
            sat = MIN_W[N_MEMBRANE-1:0];
        end else begin
            sat = sum[N_MEMBRANE-1:0];
        end
    end

    always_comb begin
        is_spike = !sat[N_MEMBRANE-1]
                   && (sat[N_MEMBRANE-2:0] >= threshold);
        new_membrane = is_spike ? '0 : sat;
    end

endmodule

// File: rtl/neuron_scheduler.sv
// Shares one neuron datapath among N_NEURONS logical neurons, walking
// them one per cycle per timestep and publishing the spike vector.
module neuron_scheduler
    import neuron_scheduler_pkg::*;
#(
    parameter int N_NEURONS   = DEF_N_NEURONS,
    parameter int N_STAGE     = DEF_N_STAGE,
    parameter int N_MEMBRANE  = N_STAGE + 2,
    parameter int N_THRESHOLD = N_MEMBRANE - 1,
    localparam int IW    = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1,
    localparam int N_SYN = 2 ** N_STAGE
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_we,
    input  logic [IW-1:0]          cfg_addr,
    input  logic [N_SYN-1:0]       cfg_weights,
    input  logic [N_THRESHOLD-1:0] cfg_threshold,
    input  logic [2:0]             cfg_shift,
    output logic                   cfg_ready,
    input  logic                   step_valid,
    input  logic [N_SYN-1:0]       step_inputs,
    output logic                   step_ready,
    output logic [N_NEURONS-1:0]   spikes,
    output logic                   spikes_valid,
    output logic                   busy
);

    localparam logic [IW-1:0] LAST  = IW'(N_NEURONS - 1);
    localparam logic [IW:0]   N_LIM = (IW + 1)'(N_NEURONS);

    state_t state;
    state_t state_nxt;

    logic [IW-1:0]    idx;
    logic [N_SYN-1:0] step_in;

    logic        [N_SYN-1:0]       weight_rf    [N_NEURONS];
    logic        [N_THRESHOLD-1:0] threshold_rf [N_NEURONS];
    logic        [2:0]             shift_rf     [N_NEURONS];
    logic signed [N_MEMBRANE-1:0]  membrane_rf  [N_NEURONS];

    logic [N_NEURONS-1:0] spike_acc;
    logic [N_NEURONS-1:0] spike_all;

    logic signed [N_MEMBRANE-1:0] new_membrane;
    logic                         is_spike;

    logic handshake;
    logic cfg_hit;
    logic last;
    logic running;

    assign step_ready   = (state == IDLE);
    assign cfg_ready    = (state == IDLE);
    assign busy         = (state != IDLE);
    assign spikes_valid = (state == DONE);

    assign running   = (state == RUN);
    assign last      = (idx == LAST);
    assign handshake = step_valid && step_ready;
    assign cfg_hit   = cfg_we && cfg_ready
                       && ({1'b0, cfg_addr} < N_LIM);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (step_valid) state_nxt = RUN;
            RUN:     if (last) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx     <= '0;
            step_in <= '0;
        end else if (handshake) begin
            idx     <= '0;
            step_in <= step_inputs;
        end else if (running) begin
            idx <= last ? '0 : idx + IW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                weight_rf[i]    <= '0;
                threshold_rf[i] <= '1;
                shift_rf[i]     <= '0;
            end
        end else if (cfg_hit) begin
            weight_rf[cfg_addr]    <= cfg_weights;
            threshold_rf[cfg_addr] <= cfg_threshold;
            shift_rf[cfg_addr]     <= cfg_shift;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N_NEURONS; i++) begin
                membrane_rf[i] <= '0;
            end
            spike_acc <= '0;
        end else if (running) begin
            membrane_rf[idx] <= new_membrane;
            spike_acc[idx]   <= is_spike;
        end
    end

    // final neuron's spike is merged in so spikes is fresh during DONE
    always_comb begin
        spike_all      = spike_acc;
        spike_all[idx] = is_spike;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            spikes <= '0;
        end else if (running && last) begin
            spikes <= spike_all;
        end
    end

    neuron #(
        .N_STAGE     (N_STAGE),
        .N_MEMBRANE  (N_MEMBRANE),
        .N_THRESHOLD (N_THRESHOLD)
    ) u_neuron (
        .inputs       (step_in),
        .weights      (weight_rf[idx]),
        .threshold    (threshold_rf[idx]),
        .shift        (shift_rf[idx]),
        .membrane     (membrane_rf[idx]),
        .new_membrane (new_membrane),
        .is_spike     (is_spike)
    );

endmodule

// File: tb/tb_neuron_scheduler.sv
// Scoreboard bench for neuron_scheduler: LIF reference model in plain
// integer arithmetic, expected spike vectors queued per step.
module tb_neuron_scheduler;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_we;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_weights;
    logic [3:0] cfg_threshold;
    logic [2:0] cfg_shift;
    logic       cfg_ready;
    logic       step_valid;
    logic [7:0] step_inputs;
    logic       step_ready;
    logic [3:0] spikes;
    logic       spikes_valid;
    logic       busy;

    logic       cfg_we3;
    logic [1:0] cfg_addr3;
    logic [7:0] cfg_weights3;
    logic [3:0] cfg_threshold3;
    logic [2:0] cfg_shift3;
    logic       cfg_ready3;
    logic       step_valid3;
    logic [7:0] step_inputs3;
    logic       step_ready3;
    logic [2:0] spikes3;
    logic       spikes_valid3;
    logic       busy3;

    neuron_scheduler dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_we        (cfg_we),
        .cfg_addr      (cfg_addr),
        .cfg_weights   (cfg_weights),
        .cfg_threshold (cfg_threshold),
        .cfg_shift     (cfg_shift),
        .cfg_ready     (cfg_ready),
        .step_valid    (step_valid),
        .step_inputs   (step_inputs),
        .step_ready    (step_ready),
        .spikes        (spikes),
        .spikes_valid  (spikes_valid),
        .busy          (busy)
    );

    neuron_scheduler #(.N_NEURONS(3)) dut3 (
        .clk           (clk),
        .rst_n         (rst_n),
        .cfg_we        (cfg_we3),
        .cfg_addr      (cfg_addr3),
        .cfg_weights   (cfg_weights3),
        .cfg_threshold (cfg_threshold3),
        .cfg_shift     (cfg_shift3),
        .cfg_ready     (cfg_ready3),
        .step_valid    (step_valid3),
        .step_inputs   (step_inputs3),
        .step_ready    (step_ready3),
        .spikes        (spikes3),
        .spikes_valid  (spikes_valid3),
        .busy          (busy3)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] spk;
        int         cyc;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;

    logic [7:0] mw [4];
    int         mt [4];
    int         ms [4];
    int         mm [4];

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < 4; i++) begin
            mw[i] = 8'h00;
            mt[i] = 15;
            ms[i] = 0;
            mm[i] = 0;
        end
    endfunction

    function automatic void model_cfg(input int a, input logic [7:0] w,
                                      input int t, input int s);
        if (a >= 0 && a < 4) begin
            mw[a] = w;
            mt[a] = t;
            ms[a] = s;
        end
    endfunction

    // one timestep of every neuron, from the leaky integrate-and-fire rule
    function automatic logic [3:0] model_step(input logic [7:0] in);
        logic [3:0] spk;
        int d;
        int sum;
        spk = '0;
        for (int i = 0; i < 4; i++) begin
            d = (ms[i] == 0) ? mm[i] : mm[i] - (mm[i] >>> ms[i]);
            sum = d + $countones(in & mw[i]);
            if (sum > 15) sum = 15;
            if (sum < -16) sum = -16;
            spk[i] = (sum >= mt[i]);
            mm[i] = spk[i] ? 0 : sum;
        end
        return spk;
    endfunction

    always @(negedge clk) begin
        if (rst_n === 1'b1 && spikes_valid === 1'b1) begin
            if (q.size() == 0) begin
                chk("unexpected_spikes_valid", 1, 0);
            end else begin
                mon_e = q.pop_front();
                chk("spikes", int'(spikes), int'(mon_e.spk));
                chk("spikes_latency", cyc, mon_e.cyc);
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        @(negedge clk);
        while (step_ready !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (step_ready !== 1'b1) chk("step_ready_timeout", 0, 1);
    endtask

    task automatic drive_cfg(input int a, input logic [7:0] w,
                             input int t, input int s);
        cfg_we        = 1'b1;
        cfg_addr      = a[1:0];
        cfg_weights   = w;
        cfg_threshold = t[3:0];
        cfg_shift     = s[2:0];
    endtask

    task automatic cfg_write(input int a, input logic [7:0] w,
                             input int t, input int s);
        wait_ready();
        drive_cfg(a, w, t, s);
        model_cfg(a, w, t, s);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    // returns at the negedge of the RUN cycle for idx 0
    task automatic step_tx(input logic [7:0] in, input bit wc,
                           input int a, input logic [7:0] w,
                           input int t, input int s);
        exp_t e;
        wait_ready();
        if (wc) begin
            drive_cfg(a, w, t, s);
            model_cfg(a, w, t, s);
        end
        step_valid  = 1'b1;
        step_inputs = in;
        e.spk = model_step(in);
        e.cyc = cyc + 4 + 1;
        q.push_back(e);
        @(negedge clk);
        step_valid = 1'b0;
        cfg_we     = 1'b0;
    endtask

    task automatic chk_mem();
        wait_ready();
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("membrane[%0d]", i),
                int'(dut.membrane_rf[i]), mm[i]);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drain", q.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        cfg_we = 1'b0; cfg_addr = '0; cfg_weights = '0;
        cfg_threshold = '0; cfg_shift = '0;
        step_valid = 1'b0; step_inputs = '0;
        cfg_we3 = 1'b0; cfg_addr3 = '0; cfg_weights3 = '0;
        cfg_threshold3 = '0; cfg_shift3 = '0;
        step_valid3 = 1'b0; step_inputs3 = '0;
        model_reset();
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        chk("rst_spikes", int'(spikes), 0);
        chk("rst_spikes_valid", int'(spikes_valid), 0);
        chk("rst_step_ready", int'(step_ready), 1);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        chk("rst_busy", int'(busy), 0);

        // neuron 0 fires on a full input vector
        cfg_write(0, 8'hFF, 7, 0);
        step_tx(8'hFF, 0, 0, 0, 0, 0);
        chk("run_busy", int'(busy), 1);
        chk("run_step_ready", int'(step_ready), 0);
        drain();
        chk_mem();

        for (int k = 0; k < 10; k++) step_tx(8'h00, 0, 0, 0, 0, 0);
        drain();
        chk_mem();

        // write during RUN is dropped, same write with handshake is used
        step_tx(8'h0F, 0, 0, 0, 0, 0);
        drive_cfg(2, 8'hFF, 0, 0);
        chk("run_cfg_ready", int'(cfg_ready), 0);
        @(negedge clk);
        cfg_we = 1'b0;
        chk("run_cfg_ignored_w", int'(dut.weight_rf[2]), 0);
        chk("run_cfg_ignored_t", int'(dut.threshold_rf[2]), 15);
        step_tx(8'hFF, 1, 2, 8'hFF, 0, 0);
        drain();
        chk_mem();

        for (int k = 0; k < 60; k++) begin
            int r;
            r = $urandom_range(0, 3);
            if (r == 0) begin
                cfg_write($urandom_range(0, 3), 8'($urandom),
                          $urandom_range(0, 9), $urandom_range(0, 7));
            end else if (r == 1) begin
                step_tx(8'($urandom), 0, 0, 0, 0, 0);
                if ($urandom_range(0, 1) == 1) begin
                    drive_cfg($urandom_range(0, 3), 8'($urandom),
                              $urandom_range(0, 15), 3);
                    @(negedge clk);
                    cfg_we = 1'b0;
                end
                chk_mem();
            end else if (r == 2) begin
                step_tx(8'($urandom), 1, $urandom_range(0, 3),
                        8'($urandom), $urandom_range(0, 9),
                        $urandom_range(0, 7));
                chk_mem();
            end else begin
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        drain();

        // abort a step in the RUN cycle for idx 2
        cfg_write(0, 8'h03, 15, 0);
        cfg_write(1, 8'h01, 15, 0);
        wait_ready();
        step_valid  = 1'b1;
        step_inputs = 8'hFF;
        @(negedge clk);
        step_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        q.delete();
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("abort_mem[%0d]", i),
                int'(dut.membrane_rf[i]), 0);
            chk($sformatf("abort_thr[%0d]", i),
                int'(dut.threshold_rf[i]), 15);
        end
        chk("abort_step_ready", int'(step_ready), 1);
        chk("abort_busy", int'(busy), 0);
        chk("abort_spikes", int'(spikes), 0);

        // three-neuron instance: address 3 is out of range
        @(negedge clk);
        cfg_we3 = 1'b1; cfg_addr3 = 2'd3;
        cfg_weights3 = 8'hFF; cfg_threshold3 = 4'd0; cfg_shift3 = 3'd5;
        @(negedge clk);
        cfg_we3 = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("n3_w[%0d]", i), int'(dut3.weight_rf[i]), 0);
            chk($sformatf("n3_t[%0d]", i), int'(dut3.threshold_rf[i]), 15);
            chk($sformatf("n3_s[%0d]", i), int'(dut3.shift_rf[i]), 0);
        end
        cfg_we3 = 1'b1; cfg_addr3 = 2'd1;
        @(negedge clk);
        cfg_we3 = 1'b0;
        chk("n3_addr1_t", int'(dut3.threshold_rf[1]), 0);
        step_valid3 = 1'b1; step_inputs3 = 8'hFF;
        @(negedge clk);
        step_valid3 = 1'b0;
        begin
            int n = 0;
            while (spikes_valid3 !== 1'b1 && n < 20) begin
                @(negedge clk);
                n++;
            end
            chk("n3_valid_seen", int'(spikes_valid3), 1);
            chk("n3_spikes", int'(spikes3), 3'b010);
        end

        drain();
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/neuron_scheduler.md
# neuron_scheduler

Time-multiplexed controller that shares one `neuron` datapath instance among `N_NEURONS` logical neurons. It holds per-neuron configuration (weights, threshold, decay shift) and membrane state in register files. On each accepted timestep it walks the neurons one per cycle, feeding the datapath and writing back the new membrane. It then presents the collected spike vector. It sits between the chip I/O wrapper and the neuron datapath.

## Interface
- `N_NEURONS`, 4: logical neurons served; ≥2.
- `N_STAGE`, 3: datapath stage parameter; synapse count per neuron is 2**N_STAGE.
- `N_MEMBRANE`, N_STAGE+2: signed membrane width.
- `N_THRESHOLD`, N_MEMBRANE-1: unsigned threshold width.

- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `cfg_we`  in  1  configuration write strobe.
- `cfg_addr`  in  clog2(N_NEURONS)  target neuron.
- `cfg_weights`  in  2**N_STAGE  synapse weights.
- `cfg_threshold`  in  N_THRESHOLD  spike threshold.
- `cfg_shift`  in  3  decay shift.
- `cfg_ready`  out  1  high when a write is accepted (IDLE only).
- `step_valid`  in  1  request one timestep.
- `step_inputs`  in  2**N_STAGE  input spikes, shared by all neurons.
- `step_ready`  out  1  high in IDLE only.
- `spikes`  out  N_NEURONS  spike vector of last completed step; bit i = neuron i.
- `spikes_valid`  out  1  one-cycle pulse when `spikes` updates.
- `busy`  out  1  high in RUN and DONE.

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE → RUN on `step_valid & step_ready`:
  - latch `step_inputs`;
  - idx := 0.
- RUN, each cycle:
  - drive the datapath with the latched inputs, weights[idx], shift[idx], threshold[idx] and membrane[idx];
  - at the clock edge, write membrane[idx] := new_membrane and spike_acc[idx] := is_spike;
  - increment idx.
- RUN → DONE after the write for idx = N_NEURONS-1.
- DONE: `spikes` := spike_acc, `spikes_valid` = 1 for this cycle only; then → IDLE.
- Config write:
  - takes effect when `cfg_we & cfg_ready` and `cfg_addr < N_NEURONS`;
  - `cfg_addr ≥ N_NEURONS` is ignored;
  - `cfg_we` outside IDLE is ignored; it is not queued.
- A config write and a step handshake in the same IDLE cycle both take effect. The step uses the newly written values.
- Membranes change only via datapath writeback. Saturation and reset behaviour are the datapath's; the scheduler adds no arithmetic.
- `step_valid` while not ready is ignored. The requester holds it until the handshake.

## Timing
- Reset values:
  - state IDLE, idx 0;
  - all membranes 0, weights 0, shifts 0;
  - thresholds all-ones (max);
  - `spikes` 0, `spikes_valid` 0, `busy` 0;
  - `step_ready` 1, `cfg_ready` 1.
- Handshake at edge t: RUN occupies cycles t+1 … t+N_NEURONS. `spikes_valid` is high in cycle t+N_NEURONS+1. `step_ready` returns high in cycle t+N_NEURONS+2.
- Step throughput: one per N_NEURONS+2 cycles.
- `spikes` holds its value until the next DONE.
- Neuron idx is processed in cycle t+1+idx; datapath is a single combinational cycle.
- `rst_n` asserted mid-RUN:
  - aborts the step immediately;
  - membranes and config return to reset values;
  - no `spikes_valid` pulse.
- idx never exceeds N_NEURONS-1; there is no wrap within a step.

## Structure
- Shared package: FSM state enum and the idx width constant (clog2(N_NEURONS)).
- Default widths also live in the package so the wrapper and the bench agree.
- One sub-module: the existing `neuron` datapath, instantiated once with N_STAGE/N_MEMBRANE/N_THRESHOLD passed through.
- Register files are flat arrays in this block; no memory macro.

## Test plan
- Reset then idle for 5 cycles: `spikes`=0, `spikes_valid`=0, `step_ready`=1, `busy`=0.
- Config neuron 0: weights 8'hFF, threshold 7, shift 0. Step with inputs 8'hFF:
  - `spikes_valid` exactly 5 cycles after the handshake (N=4);
  - `spikes[0]` and membrane[0] match the golden datapath model.
- Inputs 8'h00, all shifts 0, 10 steps: every membrane stays 0 and `spikes` stays 4'b0000.
- `cfg_we` to neuron 2 during RUN: write ignored and `cfg_ready`=0. The same write in IDLE together with a step handshake is applied and used by that step.
- `cfg_addr` ≥ N_NEURONS (N=3, addr 3): no register changes.
- `rst_n` low in the RUN cycle for idx 2: no `spikes_valid`; after release all membranes are 0, thresholds max, `step_ready`=1.
